// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM state
// encodings, requester port indices and a one-hot to index helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_ACCESS = 2'd1,
      ARB_RESP   = 2'd2
   } arb_state_t;

   localparam int unsigned ARB_PORT_IF   = 0;
   localparam int unsigned ARB_PORT_DATA = 1;
   localparam int unsigned ARB_PORT_DBG  = 2;

   function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
      if (oh[ARB_PORT_DATA]) return 2'd1;
      if (oh[ARB_PORT_DBG])  return 2'd2;
      return 2'd0;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_pick3.sv
// Combinational one-hot winner select over three requesters.
// MEM_ARB_RR_EN selects round-robin from a last-grant pointer; otherwise fixed 1 > 0 > 2.
module arb_pick3
   import mem_port_arbiter_pkg::*;
(
   input  logic [2:0] req,
`ifdef MEM_ARB_RR_EN
   input  logic [1:0] last,
`endif
   output logic [2:0] gnt
);

`ifdef MEM_ARB_RR_EN
   logic [1:0] p0, p1, p2;

   // Search order begins one past the last grant, wrapping modulo 3.
   always_comb begin
      case (last)
         2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
         2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
         default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
      endcase
      gnt = '0;
      if (req[p0])      gnt[p0] = 1'b1;
      else if (req[p1]) gnt[p1] = 1'b1;
      else if (req[p2]) gnt[p2] = 1'b1;
   end
`else
   always_comb begin
      gnt = '0;
      if (req[ARB_PORT_DATA])    gnt[ARB_PORT_DATA] = 1'b1;
      else if (req[ARB_PORT_IF]) gnt[ARB_PORT_IF]   = 1'b1;
      else if (req[ARB_PORT_DBG]) gnt[ARB_PORT_DBG] = 1'b1;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Three-port arbiter for the unified memory port with a ready handshake and
// watchdog timeout. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 26,
   parameter int DATA_W  = 32,
   parameter int TMO_W   = 4,
   parameter int TMO_CYC = 12
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [2:0]            REQ,
   input  logic [2:0]            WE,
   input  logic [3*ADDR_W-1:0]   ADDR,
   input  logic [3*DATA_W-1:0]   WDATA,
   output logic [2:0]            GNT,
   output logic [2:0]            DONE,
   output logic                  ERR,
   output logic [DATA_W-1:0]     RDATA,
   output logic [ADDR_W-1:0]     MEM_ADDR,
   output logic [DATA_W-1:0]     MEM_WDATA,
   output logic                  MEM_READ,
   output logic                  MEM_WRITE,
   input  logic [DATA_W-1:0]     MEM_RDATA,
   input  logic                  MEM_READY,
   output logic                  BUSY
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   arb_state_t       state;
   logic [TMO_W-1:0] tmo_cnt;
   logic [2:0]       pick;
   logic [1:0]       widx;

`ifdef MEM_ARB_RR_EN
   logic [1:0] last_q;

   arb_pick3 u_pick (.req(REQ), .last(last_q), .gnt(pick));
`else
   arb_pick3 u_pick (.req(REQ), .gnt(pick));
`endif

   assign widx = onehot_idx(pick);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= ARB_IDLE;
         tmo_cnt   <= '0;
         GNT       <= '0;
         DONE      <= '0;
         ERR       <= 1'b0;
         RDATA     <= '0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         MEM_READ  <= 1'b0;
         MEM_WRITE <= 1'b0;
         BUSY      <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_q    <= 2'd2;
`endif
      end else begin
         DONE <= '0;
         case (state)
            ARB_IDLE: begin
               if (|REQ) begin
                  GNT       <= pick;
                  MEM_ADDR  <= ADDR[widx*ADDR_W +: ADDR_W];
                  MEM_WDATA <= WDATA[widx*DATA_W +: DATA_W];
                  MEM_READ  <= ~WE[widx];
                  MEM_WRITE <= WE[widx];
                  BUSY      <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               // A ready on the final watchdog cycle still completes cleanly.
               if (MEM_READY) begin
                  if (MEM_READ) RDATA <= MEM_RDATA;
                  MEM_READ  <= 1'b0;
                  MEM_WRITE <= 1'b0;
                  DONE      <= GNT;
                  ERR       <= 1'b0;
                  state     <= ARB_RESP;
               end else if (tmo_cnt == TMO_LAST) begin
                  MEM_READ  <= 1'b0;
                  MEM_WRITE <= 1'b0;
                  DONE      <= GNT;
                  ERR       <= 1'b1;
                  state     <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               GNT       <= '0;
               ERR       <= 1'b0;
               tmo_cnt   <= '0;
               MEM_ADDR  <= '0;
               MEM_WDATA <= '0;
               BUSY      <= 1'b0;
`ifdef MEM_ARB_RR_EN
               last_q    <= onehot_idx(GNT);
`endif
               state     <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule
